// File: rtl/spatz_tcdm_amo_bank.sv
// Per-bank TCDM adapter: 1-cycle SRAM pass-through plus local AMO / LR / SC execution.
// Atomics are built only when SPATZ_TCDM_AMO_EN is defined; otherwise every request is a plain access.
module spatz_tcdm_amo_bank #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic                 q_write_i,
    input  logic [3:0]           q_amo_i,
    input  logic [DataWidth-1:0] q_data_i,
    input  logic [StrbWidth-1:0] q_strb_i,
    output logic                 p_valid_o,
    output logic [DataWidth-1:0] p_data_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [StrbWidth-1:0] sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    // Handshake: a request is taken on q_valid_i & q_ready_o; its response appears exactly one cycle later.
    logic                 accept;
    logic                 p_valid_q;
    logic [DataWidth-1:0] rdata_sel;

`ifdef SPATZ_TCDM_AMO_EN
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] AMO_WB = 1'b1;

    localparam logic [3:0] AMO_NONE = 4'd0;
    localparam logic [3:0] AMO_SWAP = 4'd1;
    localparam logic [3:0] AMO_ADD  = 4'd2;
    localparam logic [3:0] AMO_AND  = 4'd3;
    localparam logic [3:0] AMO_OR   = 4'd4;
    localparam logic [3:0] AMO_XOR  = 4'd5;
    localparam logic [3:0] AMO_MAX  = 4'd6;
    localparam logic [3:0] AMO_MAXU = 4'd7;
    localparam logic [3:0] AMO_MIN  = 4'd8;
    localparam logic [3:0] AMO_MINU = 4'd9;
    localparam logic [3:0] AMO_LR   = 4'd10;
    localparam logic [3:0] AMO_SC   = 4'd11;

    logic [0:0]           state_q, state_d;
    logic [3:0]           op;
    logic                 is_rmw, is_lr, is_sc, is_store, sc_ok;
    logic [AddrWidth-1:0] amo_addr_q;
    logic [3:0]           amo_op_q;
    logic [DataWidth-1:0] amo_operand_q, amo_result;
    logic                 res_valid_q;
    logic [AddrWidth-1:0] res_addr_q;
    logic                 resp_sc_q, resp_sc_ok_q;

    // Opcodes 12-15 fall back to a plain access.
    assign op       = (q_amo_i > AMO_SC) ? AMO_NONE : q_amo_i;
    assign is_rmw   = (op != AMO_NONE) && (op <= AMO_MINU);
    assign is_lr    = (op == AMO_LR);
    assign is_sc    = (op == AMO_SC);
    assign is_store = (op == AMO_NONE) && q_write_i;
    assign sc_ok    = res_valid_q && (res_addr_q == q_addr_i);

    assign q_ready_o = !rst_i && (state_q == IDLE);
    assign accept    = q_valid_i && q_ready_o;

    always_comb begin
        amo_result = amo_operand_q;
        case (amo_op_q)
            AMO_SWAP: amo_result = amo_operand_q;
            AMO_ADD:  amo_result = sram_rdata_i + amo_operand_q;
            AMO_AND:  amo_result = sram_rdata_i & amo_operand_q;
            AMO_OR:   amo_result = sram_rdata_i | amo_operand_q;
            AMO_XOR:  amo_result = sram_rdata_i ^ amo_operand_q;
            AMO_MAX:  amo_result = ($signed(sram_rdata_i) > $signed(amo_operand_q)) ? sram_rdata_i : amo_operand_q;
            AMO_MAXU: amo_result = (sram_rdata_i > amo_operand_q) ? sram_rdata_i : amo_operand_q;
            AMO_MIN:  amo_result = ($signed(sram_rdata_i) < $signed(amo_operand_q)) ? sram_rdata_i : amo_operand_q;
            AMO_MINU: amo_result = (sram_rdata_i < amo_operand_q) ? sram_rdata_i : amo_operand_q;
            default:  amo_result = amo_operand_q;
        endcase
    end

    // The write-back is dropped if reset lands in the AMO_WB cycle.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = q_addr_i;
        sram_wdata_o = q_data_i;
        sram_be_o    = q_strb_i;
        if (state_q == AMO_WB) begin
            sram_req_o   = !rst_i;
            sram_we_o    = 1'b1;
            sram_addr_o  = amo_addr_q;
            sram_wdata_o = amo_result;
            sram_be_o    = '1;
        end else begin
            sram_req_o = accept && !(is_sc && !sc_ok);
            sram_we_o  = is_sc || is_store;
            if (is_sc) sram_be_o = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_rmw) state_d = AMO_WB;
            AMO_WB:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            amo_addr_q    <= '0;
            amo_op_q      <= AMO_NONE;
            amo_operand_q <= '0;
            res_valid_q   <= 1'b0;
            res_addr_q    <= '0;
            resp_sc_q     <= 1'b0;
            resp_sc_ok_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_sc_q    <= accept && is_sc;
            resp_sc_ok_q <= sc_ok;
            if (accept && is_rmw) begin
                amo_addr_q    <= q_addr_i;
                amo_op_q      <= op;
                amo_operand_q <= q_data_i;
            end
            // Any write reaching the reserved word kills the reservation on the same edge.
            if (state_q == AMO_WB) begin
                if (amo_addr_q == res_addr_q) res_valid_q <= 1'b0;
            end else if (accept) begin
                if (is_lr) begin
                    res_valid_q <= 1'b1;
                    res_addr_q  <= q_addr_i;
                end else if (is_sc) begin
                    res_valid_q <= 1'b0;
                end else if (is_store && (q_addr_i == res_addr_q)) begin
                    res_valid_q <= 1'b0;
                end
            end
        end
    end

    assign rdata_sel = resp_sc_q ? {{(DataWidth-1){1'b0}}, !resp_sc_ok_q} : sram_rdata_i;
`else
    logic unused_amo;

    assign unused_amo   = ^q_amo_i;
    assign q_ready_o    = !rst_i;
    assign accept       = q_valid_i && q_ready_o;
    assign sram_req_o   = accept;
    assign sram_we_o    = q_write_i;
    assign sram_addr_o  = q_addr_i;
    assign sram_wdata_o = q_data_i;
    assign sram_be_o    = q_strb_i;
    assign rdata_sel    = sram_rdata_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) p_valid_q <= 1'b0;
        else       p_valid_q <= accept;
    end

    assign p_valid_o = p_valid_q;
    assign p_data_o  = p_valid_q ? rdata_sel : '0;

endmodule

// File: tb/tb_spatz_tcdm_amo_bank.sv
// Self-checking bench for spatz_tcdm_amo_bank: SRAM model, transaction-level reference model, scoreboard.
// Follows SPATZ_TCDM_AMO_EN the same way the design does.
module tb_spatz_tcdm_amo_bank;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int MEM = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          q_valid_i;
    logic          q_ready_o;
    logic [AW-1:0] q_addr_i;
    logic          q_write_i;
    logic [3:0]    q_amo_i;
    logic [DW-1:0] q_data_i;
    logic [SW-1:0] q_strb_i;
    logic          p_valid_o;
    logic [DW-1:0] p_data_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [SW-1:0] sram_be_o;
    logic [DW-1:0] sram_rdata_i;

    spatz_tcdm_amo_bank #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
        .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
        .p_valid_o(p_valid_o), .p_data_o(p_data_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // ---------------- SRAM macro model ----------------
    logic [DW-1:0] sram_mem [MEM];
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < SW; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o[3:0]][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o[3:0]];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] ref_mem [MEM];
    logic [DW-1:0] exp_q [$];
    logic          chk_q [$];
    bit            chk_en = 1'b0;
    bit            in_wb  = 1'b0;
    bit            res_v  = 1'b0;
    logic [AW-1:0] res_a  = '0;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [DW-1:0] amo_calc(input logic [3:0] op, input logic [DW-1:0] old, input logic [DW-1:0] d);
        case (op)
            4'd1:    return d;
            4'd2:    return old + d;
            4'd3:    return old & d;
            4'd4:    return old | d;
            4'd5:    return old ^ d;
            4'd6:    return ($signed(old) >= $signed(d)) ? old : d;
            4'd7:    return (old >= d) ? old : d;
            4'd8:    return ($signed(old) <= $signed(d)) ? old : d;
            4'd9:    return (old <= d) ? old : d;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] eff_op(input logic [3:0] raw);
`ifdef SPATZ_TCDM_AMO_EN
        return (raw > 4'd11) ? 4'd0 : raw;
`else
        return (raw == raw) ? 4'd0 : 4'd0;
`endif
    endfunction

    task automatic model_accept();
        logic [3:0]    op;
        logic [DW-1:0] old;
        op  = eff_op(q_amo_i);
        old = ref_mem[q_addr_i[3:0]];
        if (op == 4'd0) begin
            if (q_write_i) begin
                for (int b = 0; b < SW; b++)
                    if (q_strb_i[b]) ref_mem[q_addr_i[3:0]][b*8 +: 8] = q_data_i[b*8 +: 8];
                if (res_v && res_a == q_addr_i) res_v = 1'b0;
                exp_q.push_back('0); chk_q.push_back(1'b0);
            end else begin
                exp_q.push_back(old); chk_q.push_back(1'b1);
            end
        end else if (op <= 4'd9) begin
            exp_q.push_back(old); chk_q.push_back(1'b1);
            wb_addr = q_addr_i;
            wb_val  = amo_calc(op, old, q_data_i);
            in_wb   = 1'b1;
        end else if (op == 4'd10) begin
            exp_q.push_back(old); chk_q.push_back(1'b1);
            res_v = 1'b1;
            res_a = q_addr_i;
        end else begin
            if (res_v && res_a == q_addr_i) begin
                ref_mem[q_addr_i[3:0]] = q_data_i;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back({{(DW-1){1'b0}}, 1'b1});
            end
            chk_q.push_back(1'b1);
            res_v = 1'b0;
        end
    endtask

    logic          m_ready, m_pvalid, m_chk, m_acc, m_scfail, m_req;
    logic [DW-1:0] m_data;

    always @(negedge clk) begin
        if (chk_en) begin
            m_ready = !rst_i && !in_wb;
            check("q_ready", q_ready_o, m_ready);
            m_pvalid = (exp_q.size() > 0);
            m_chk    = 1'b0;
            m_data   = '0;
            if (m_pvalid) begin
                m_data = exp_q.pop_front();
                m_chk  = chk_q.pop_front();
            end
            check("p_valid", p_valid_o, m_pvalid);
            if (m_pvalid && m_chk) check("p_data", p_data_o, m_data);
            m_acc    = q_valid_i && m_ready;
            m_scfail = m_acc && (eff_op(q_amo_i) == 4'd11) && !(res_v && res_a == q_addr_i);
            m_req    = !rst_i && (in_wb || (m_acc && !m_scfail));
            check("sram_req", sram_req_o, m_req);
            if (in_wb) begin
                if (!rst_i) begin
                    ref_mem[wb_addr[3:0]] = wb_val;
                    if (res_v && res_a == wb_addr) res_v = 1'b0;
                end
                in_wb = 1'b0;
            end
            if (rst_i) res_v = 1'b0;
            if (m_acc) model_accept();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [AW-1:0] a, input logic w, input logic [3:0] op,
                        input logic [DW-1:0] d, input logic [SW-1:0] s, output logic req_seen);
        int n;
        q_valid_i = 1'b1; q_addr_i = a; q_write_i = w; q_amo_i = op; q_data_i = d; q_strb_i = s;
        n = 0;
        @(negedge clk);
        while (!q_ready_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++; fails++;
            $display("FAIL accept_timeout: request to %0h never accepted (t=%0t)", a, $time);
        end
        req_seen = sram_req_o;
        @(posedge clk); #1;
        q_valid_i = 1'b0;
    endtask

    task automatic send_get(input logic [AW-1:0] a, input logic w, input logic [3:0] op,
                            input logic [DW-1:0] d, input logic [SW-1:0] s,
                            output logic [DW-1:0] data, output logic rdy, output logic req_seen);
        send(a, w, op, d, s, req_seen);
        @(negedge clk);
        data = p_data_o;
        rdy  = q_ready_o;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] r;
    logic          rdy, rq;

    initial begin
        for (int i = 0; i < MEM; i++) begin
            ref_mem[i]  = $urandom();
            sram_mem[i] = ref_mem[i];
        end
        sram_rdata_i = '0;
        rst_i = 1'b1; q_valid_i = 1'b0; q_addr_i = '0; q_write_i = 1'b0;
        q_amo_i = '0; q_data_i = '0; q_strb_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p_valid", p_valid_o, 0);
        check("reset_p_data", p_data_o, 0);
        check("reset_sram_req", sram_req_o, 0);
        check("reset_q_ready", q_ready_o, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;

        // store then load back to back
        send(5, 1'b1, 4'd0, 32'hDEADBEEF, 4'hF, rq);
        send_get(5, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("load_deadbeef", r, 32'hDEADBEEF);

`ifdef SPATZ_TCDM_AMO_EN
        send(3, 1'b1, 4'd0, 32'd10, 4'hF, rq);
        send_get(3, 1'b0, 4'd2, 32'd5, 4'hF, r, rdy, rq);
        check("amo_add_old", r, 32'd10);
        check("amo_add_ready_low", rdy, 0);
        send_get(3, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("amo_add_result", r, 32'd15);

        send(7, 1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, rq);
        send(7, 1'b0, 4'd6, 32'd1, 4'hF, rq);
        send_get(7, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("amo_max_signed", r, 32'd1);
        send(7, 1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, rq);
        send(7, 1'b0, 4'd7, 32'd1, 4'hF, rq);
        send_get(7, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("amo_maxu_keeps", r, 32'hFFFFFFFF);

        send(9, 1'b0, 4'd10, '0, 4'hF, rq);
        send_get(9, 1'b0, 4'd11, 32'd42, 4'hF, r, rdy, rq);
        check("sc_success_resp", r, 32'd0);
        check("sc_success_req", rq, 1);
        send_get(9, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("sc_success_mem", r, 32'd42);

        send(9, 1'b0, 4'd10, '0, 4'hF, rq);
        send(9, 1'b1, 4'd0, 32'd77, 4'hF, rq);
        send_get(9, 1'b0, 4'd11, 32'd42, 4'hF, r, rdy, rq);
        check("sc_fail_resp", r, 32'd1);
        check("sc_fail_no_req", rq, 0);
        send_get(9, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("sc_fail_mem", r, 32'd77);

        // reset lands in the write-back cycle of a swap
        send(2, 1'b1, 4'd0, 32'h1234, 4'hF, rq);
        send(2, 1'b0, 4'd1, 32'h55, 4'hF, rq);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_wb_no_req", sram_req_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_wb_no_resp", p_valid_o, 0);
        check("rst_wb_ready", q_ready_o, 1);
        @(posedge clk); #1;
        send_get(2, 1'b0, 4'd0, '0, 4'hF, r, rdy, rq);
        check("rst_wb_mem_kept", r, 32'h1234);
`else
        send_get(5, 1'b0, 4'd2, 32'd5, 4'hF, r, rdy, rq);
        check("plain_op2_load", r, 32'hDEADBEEF);
        check("plain_op2_ready", rdy, 1);
        send(6, 1'b1, 4'd11, 32'hA5A5_0F0F, 4'h5, rq);
        send_get(6, 1'b0, 4'd10, '0, 4'hF, r, rdy, rq);
        check("plain_strb_merge", r[23:16], 8'hA5);
`endif

        // randomized traffic, narrow address range to hit reservations
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send($urandom_range(0, 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom(), 4'($urandom_range(0, 15)), rq);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < MEM; i++) check($sformatf("mem_%0d", i), sram_mem[i], ref_mem[i]);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spatz_tcdm_amo_bank.md
# spatz_tcdm_amo_bank

Per-bank memory-side adapter between one output port of the Spatz cluster TCDM interconnect and one single-port SRAM macro. It passes reads and writes straight through with a fixed 1-cycle response latency, so the interconnect's shift-register response tracking stays valid. It also executes RISC-V atomics (AMO read-modify-write, LR/SC) locally in the bank. One instance per TCDM bank.

## Interface
Parameters:
- AddrWidth, 32: bank-local word address width (interconnect MemAddrWidth).
- DataWidth, 32: word width in bits; legal values 32 or 64.
- StrbWidth, DataWidth/8: byte-enable width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_addr_i  in  AddrWidth  word address.
- q_write_i  in  1  1 = store.
- q_amo_i  in  4  atomic opcode: 0 None, 1 Swap, 2 Add, 3 And, 4 Or, 5 Xor, 6 Max, 7 Maxu, 8 Min, 9 Minu, 10 LR, 11 SC.
- q_data_i  in  DataWidth  write data / AMO operand.
- q_strb_i  in  StrbWidth  byte enables (plain stores only).
- p_valid_o  out  1  response valid.
- p_data_o  out  DataWidth  read data / AMO old value / SC result.
- sram_req_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  StrbWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after a read.

## Operation
- FSM states: IDLE, AMO_WB.
- Request handshake: accepted on q_valid_i & q_ready_o. q_ready_o = (state == IDLE).
- Plain access (amo = 0) in IDLE:
  - SRAM is driven combinationally in the same cycle: sram_req_o = 1, sram_we_o = q_write_i, sram_be_o = q_strb_i.
  - Writes return a response, but p_data_o is don't-care.
- AMO ops 1–9:
  - Cycle 0: SRAM read of the target word. Latch address, operand and opcode. Go to AMO_WB.
  - Cycle 1 (AMO_WB): p_data_o = sram_rdata_i (old value). Write the result back with full byte enables. Go to IDLE.
  - Result: op(old, operand), wrapping add. Max and Min compare signed; Maxu and Minu compare unsigned; all at full DataWidth.
- LR: read as a plain access, and set the reservation to {valid = 1, addr}.
- SC:
  - Succeeds iff the reservation is valid and its address equals q_addr_i.
  - Success: write with full byte enables in cycle 0, and p_data_o = 0 in cycle 1.
  - Failure: no SRAM access (sram_req_o = 0), and p_data_o = 1 in cycle 1.
  - The reservation is cleared in both cases.
- Reservation invalidation: any accepted store, AMO 1–9 write-back, or successful SC to the reserved address clears it. Another LR overwrites it.
- Unknown opcodes (12–15) are treated as opcode 0.

## Timing
- Response latency is exactly 1 cycle for every accepted request. p_valid_o is registered and equals the accept of the previous cycle.
- For AMO 1–9, q_ready_o = 0 during AMO_WB. This forces one bubble, so the next accept happens no earlier than cycle 2.
- Plain requests, LR and SC sustain one accept per cycle.
- sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are combinational from the inputs in IDLE, and from latched state in AMO_WB.
- In AMO_WB, the write-back to the reserved address and the reservation clear take effect at the same clock edge.
- Reset values:
  - state = IDLE.
  - p_valid_o = 0; p_data_o = 0.
  - Reservation invalid.
  - sram_req_o = 0 while rst_i is high. rst_i also gates q_ready_o to 0.
- Reset asserted mid-AMO: the pending write-back is dropped, and there is no response in the following cycle.

## Configuration
- SPATZ_TCDM_AMO_EN defined: full AMO, LR and SC support as described above.
- SPATZ_TCDM_AMO_EN undefined:
  - q_amo_i is ignored and every request is a plain read or write.
  - The AMO_WB state, ALU and reservation are not built.
  - q_ready_o = !rst_i.

## Test plan
- Store 0xDEADBEEF to addr 5 with strb 0xF, then load addr 5 → p_valid_o 1 cycle after each accept; load returns 0xDEADBEEF; two accepts in consecutive cycles.
- mem[3] = 10, AMO Add operand 5 → p_data_o = 10; q_ready_o low for one cycle; a subsequent load returns 15.
- mem[7] = 0xFFFFFFFF, Max operand 1 → stores 1 (signed); Maxu operand 1 → mem stays 0xFFFFFFFF.
- LR addr 9, then SC addr 9 data 42 → SC p_data_o = 0 and mem[9] = 42. LR addr 9, store addr 9, then SC addr 9 → SC p_data_o = 1, sram_req_o = 0 on the SC cycle, and memory keeps the store value.
- AMO Swap accepted, rst_i asserted in the AMO_WB cycle → no SRAM write, p_valid_o = 0 next cycle, q_ready_o = 1 after reset release.
- With SPATZ_TCDM_AMO_EN undefined, issue opcode 2 with write = 0 → behaves as a plain load; q_ready_o never drops.
